// File: rtl/srm_exec_ctrl.sv
// Multicycle execute controller for the Simple RISC Machine.
// Accepts one decoded instruction at a time, sequences the register file
// reads, shifts operand B, runs the ALU, writes back and keeps Z/N/V.
module srm_exec_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  rf_anum,
  output logic [2:0]  rf_bnum,
  input  logic [15:0] rf_a_out,
  input  logic [15:0] rf_b_out,
  output logic [2:0]  rf_writenum,
  output logic        rf_write,
  output logic [15:0] rf_data_in,
  output logic        done,
  output logic        illegal,
  output logic        z,
  output logic        n,
  output logic        v
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, EXEC, WRITE, WRITE_IMM, FAULT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] ir, a, b, c;
  logic [2:0]  wr_num_q;
  logic [15:0] wr_data_q;
  logic [15:0] b_sh, alu_c, diff;

  // Fields of the registered instruction
  logic [2:0] opc, rn, rd, rm;
  logic [1:0] op, sh;
  assign opc = ir[15:13];
  assign op  = ir[12:11];
  assign rn  = ir[10:8];
  assign rd  = ir[7:5];
  assign sh  = ir[4:3];
  assign rm  = ir[2:0];

  logic is_cmp;
  assign is_cmp = (opc == 3'b101) && (op == 2'b01);

  logic accept;
  assign instr_ready = (state == IDLE) && rst_n;
  assign accept      = instr_valid && instr_ready;

  // Read indices come straight from the instruction register; they are
  // only consumed by the register file in LOAD_A / LOAD_B.
  assign rf_anum = rn;
  assign rf_bnum = rm;

  // First state of an instruction, decoded from the incoming word at accept
  function automatic state_t first_state(input logic [15:0] w);
    case ({w[15:13], w[12:11]})
      5'b110_10: first_state = WRITE_IMM;
      5'b110_00: first_state = LOAD_B;
      5'b101_11: first_state = LOAD_B;
      5'b101_00,
      5'b101_01,
      5'b101_10: first_state = LOAD_A;
      default:   first_state = FAULT;
    endcase
  endfunction

  // Barrel-free single-step shifter on operand B
  always_comb begin
    case (sh)
      2'b01:   b_sh = {b[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b[15:1]};
      2'b11:   b_sh = {b[15], b[15:1]};
      default: b_sh = b;
    endcase
  end

  // ALU; CMP uses diff directly for the flags
  assign diff = a - b_sh;
  always_comb begin
    case ({opc, op})
      5'b101_00: alu_c = a + b_sh;
      5'b101_10: alu_c = a & b_sh;
      5'b101_11: alu_c = ~b_sh;
      default:   alu_c = b_sh;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and register file / status outputs
  always_comb begin
    state_nx    = state;
    rf_write    = 1'b0;
    rf_writenum = wr_num_q;
    rf_data_in  = wr_data_q;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE:   if (accept) state_nx = first_state(instr);
      LOAD_A: state_nx = LOAD_B;
      LOAD_B: state_nx = EXEC;
      EXEC: begin
        if (is_cmp) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        rf_write    = 1'b1;
        rf_writenum = rd;
        rf_data_in  = c;
        done        = 1'b1;
        state_nx    = IDLE;
      end
      WRITE_IMM: begin
        rf_write    = 1'b1;
        rf_writenum = rn;
        rf_data_in  = {{8{ir[7]}}, ir[7:0]};
        done        = 1'b1;
        state_nx    = IDLE;
      end
      FAULT: begin
        done     = 1'b1;
        illegal  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: instruction, operands, result, flags, write hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      v         <= 1'b0;
      wr_num_q  <= '0;
      wr_data_q <= '0;
    end else begin
      if (accept)            ir <= instr;
      if (state == LOAD_A)   a  <= rf_a_out;
      if (state == LOAD_B)   b  <= rf_b_out;
      if (state == EXEC) begin
        if (is_cmp) begin
          z <= (diff == 16'h0000);
          n <= diff[15];
          v <= (a[15] != b_sh[15]) && (diff[15] != a[15]);
        end else begin
          c <= alu_c;
        end
      end
      if (rf_write) begin
        wr_num_q  <= rf_writenum;
        wr_data_q <= rf_data_in;
      end
    end
  end

endmodule

// File: tb/tb_srm_exec_ctrl.sv
// Directed bench for srm_exec_ctrl with a behavioural 8x16 register file.
module tb_srm_exec_ctrl;

  logic        clk, rst_n, instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_anum, rf_bnum, rf_writenum;
  logic [15:0] rf_a_out, rf_b_out, rf_data_in;
  logic        rf_write, done, illegal, z, n, v;

  int passed = 0;
  int total  = 0;

  srm_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_anum(rf_anum), .rf_bnum(rf_bnum),
    .rf_a_out(rf_a_out), .rf_b_out(rf_b_out), .rf_writenum(rf_writenum),
    .rf_write(rf_write), .rf_data_in(rf_data_in), .done(done),
    .illegal(illegal), .z(z), .n(n), .v(v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model with a bench-side preload port
  logic [15:0] rf [8];
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [15:0] pre_val;
  assign rf_a_out = rf[rf_anum];
  assign rf_b_out = rf[rf_bnum];
  always @(posedge clk) begin
    if (pre_we)        rf[pre_idx]     <= pre_val;
    else if (rf_write) rf[rf_writenum] <= rf_data_in;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic poke(input logic [2:0] idx, input logic [15:0] val);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Offer at a negedge; returns at the negedge of cycle 1 after accept
  task automatic issue(input logic [15:0] w);
    instr_valid = 1'b1; instr = w;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'hFFFF;
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    pre_we = 1'b0; pre_idx = 3'd0; pre_val = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    @(negedge clk); @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_write", rf_write, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_flags", {z, n, v}, 0);
    chk("rst_wnum", rf_writenum, 0);
    chk("rst_wdata", rf_data_in, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", instr_ready, 1);

    // MOV R0,#0xFD
    issue(16'hD0FD);
    chk("movi_write", rf_write, 1);
    chk("movi_wnum", rf_writenum, 0);
    chk("movi_data", rf_data_in, 16'hFFFD);
    chk("movi_done", done, 1);
    chk("movi_illegal", illegal, 0);
    chk("movi_ready_busy", instr_ready, 0);
    @(negedge clk);
    chk("movi_ready_after", instr_ready, 1);
    chk("movi_r0", rf[0], 16'hFFFD);

    // ADD R3,R1,R2 LSL1
    poke(3'd1, 16'h0005);
    poke(3'd2, 16'h0007);
    issue(16'hA16A);
    chk("add_anum", rf_anum, 1);
    chk("add_c1_done", done, 0);
    @(negedge clk);
    chk("add_bnum", rf_bnum, 2);
    @(negedge clk);
    chk("add_c3_write", rf_write, 0);
    chk("add_c3_done", done, 0);
    @(negedge clk);
    chk("add_write", rf_write, 1);
    chk("add_wnum", rf_writenum, 3);
    chk("add_data", rf_data_in, 16'h0013);
    chk("add_done", done, 1);
    chk("add_flags", {z, n, v}, 0);
    @(negedge clk);
    chk("add_ready_after", instr_ready, 1);
    chk("add_r3", rf[3], 16'h0013);

    // CMP R1,R2 with signed overflow
    poke(3'd1, 16'h7FFF);
    poke(3'd2, 16'hFFFF);
    issue(16'hA902);
    chk("cmp_c1_write", rf_write, 0);
    @(negedge clk);
    chk("cmp_c2_write", rf_write, 0);
    chk("cmp_c2_done", done, 0);
    @(negedge clk);
    chk("cmp_done", done, 1);
    chk("cmp_c3_write", rf_write, 0);
    @(negedge clk);
    chk("cmp_flags", {z, n, v}, 3'b011);
    chk("cmp_ready_after", instr_ready, 1);

    // CMP R1,R1 -> zero
    issue(16'hA901);
    @(negedge clk);
    @(negedge clk);
    chk("cmpz_done", done, 1);
    @(negedge clk);
    chk("cmpz_flags", {z, n, v}, 3'b100);

    // MVN R5,R4 LSR1 then ASR1
    poke(3'd4, 16'h8000);
    issue(16'hB8B4);
    chk("mvn_c1_write", rf_write, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mvn_write", rf_write, 1);
    chk("mvn_wnum", rf_writenum, 5);
    chk("mvn_lsr_data", rf_data_in, 16'hBFFF);
    @(negedge clk);
    issue(16'hB8BC);
    @(negedge clk);
    @(negedge clk);
    chk("mvn_asr_data", rf_data_in, 16'h3FFF);
    chk("mvn_asr_done", done, 1);
    @(negedge clk);
    chk("mvn_r5", rf[5], 16'h3FFF);
    chk("mvn_flags_kept", {z, n, v}, 3'b100);

    // Undefined opcode
    issue(16'hE000);
    chk("ill_done", done, 1);
    chk("ill_illegal", illegal, 1);
    chk("ill_write", rf_write, 0);
    @(negedge clk);
    chk("ill_ready_after", instr_ready, 1);
    chk("ill_illegal_off", illegal, 0);
    chk("ill_flags_kept", {z, n, v}, 3'b100);

    // ADD R3,R1,R2 LSL1 aborted by reset during EXEC
    issue(16'hA16A);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_write", rf_write, 0);
    chk("abort_ready", instr_ready, 0);
    @(negedge clk);
    chk("abort_write_hold", rf_write, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", instr_ready, 1);
    chk("abort_flags", {z, n, v}, 0);
    chk("abort_r3", rf[3], 16'h0013);
    chk("abort_write_after", rf_write, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/srm_exec_ctrl.md
Name: srm_exec_ctrl

Overview:
- Multicycle execute controller for the Simple RISC Machine.
- Sits directly upstream of the 8x16 register file: accepts one decoded 16-bit instruction at a time and drives the register file's read/write ports.
- Latches operands A/B from the register file read outputs, shifts B, runs the ALU and writes the result back.
- Maintains Z/N/V status flags.

Parameters:
- none (data width fixed at 16, register index width fixed at 3)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr  in  16  instruction word: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8
- instr_ready  out  1  high only in IDLE with rst_n high; transfer occurs on any edge where valid&ready
- rf_anum  out  3  register file read index A
- rf_bnum  out  3  register file read index B
- rf_a_out  in  16  register file read data A (combinational from rf_anum)
- rf_b_out  in  16  register file read data B (combinational from rf_bnum)
- rf_writenum  out  3  register file write index
- rf_write  out  1  register file write enable; register is written on the edge ending the cycle
- rf_data_in  out  16  register file write data
- done  out  1  one-cycle pulse in the final cycle of every instruction, including illegal instructions
- illegal  out  1  one-cycle pulse, coincident with done, for an undefined encoding
- z, n, v  out  1 each  status flags: zero, negative, signed overflow

Behaviour:
- Reset (async, rst_n low):
  - state forced to IDLE, instruction register cleared, A/B/C registers cleared, z/n/v cleared.
  - rf_write, done and illegal deassert immediately, without waiting for a clock edge.
  - all other outputs = 0.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE, WRITE_IMM, FAULT.
- Accept:
  - instr is captured into the internal instruction register on the accept edge.
  - decode uses only the registered copy; instr may change after acceptance.
- Transitions from IDLE on accept:
  - MOV imm (110,10) -> WRITE_IMM.
  - MOV reg (110,00) -> LOAD_B.
  - MVN (101,11) -> LOAD_B.
  - ADD/CMP/AND (101,00/01/10) -> LOAD_A.
  - any other opcode/op pair -> FAULT.
- LOAD_A: rf_anum=Rn; A<=rf_a_out at the edge; next state LOAD_B.
- LOAD_B: rf_bnum=Rm; B<=rf_b_out at the edge; next state EXEC.
- Shifter on B, 16-bit:
  - 00 pass.
  - 01 LSL1 (bit0=0).
  - 10 LSR1 (bit15=0).
  - 11 ASR1 (bit15 kept).
- EXEC: C<=ALU(A, sh(B)). Results truncated to 16 bits.
  - ADD: A+sh.
  - AND: A&sh.
  - MVN: ~sh.
  - MOV reg: sh (A ignored).
  - CMP: A-sh, which sets:
    - z = (diff==0)
    - n = diff[15]
    - v = (A[15]!=sh[15]) & (diff[15]!=A[15])
  - CMP: C is not written, and done pulses in EXEC. Next state IDLE.
  - all others: next state WRITE.
- Flags change only on CMP; all other instructions leave z/n/v unchanged.
- WRITE: rf_write=1, rf_writenum=Rd, rf_data_in=C, done=1; next state IDLE.
- WRITE_IMM: rf_write=1, rf_writenum=Rn, rf_data_in=sign-extended imm8, done=1; next state IDLE.
- FAULT: done=1, illegal=1, rf_write=0; next state IDLE. No register or flag change.
- Outside write states, rf_write=0 and rf_writenum/rf_data_in hold their last driven values (don't-care to the register file).
- Latency, counted in cycles after the accept edge (done cycle = last):
  - MOV imm 1.
  - FAULT 1.
  - MOV reg/MVN 3.
  - CMP 3.
  - ADD/AND 4.
- instr_ready reasserts the cycle after done; back-to-back issue has one IDLE cycle between instructions.
- Reads that depend on a preceding write see the new value: the write commits on the done edge, and LOAD_* occurs at least 2 cycles later.
- Rn==Rm and Rd==Rn/Rm are legal. Operands are latched before the write, so the result uses the old values.
- instr_valid is ignored outside IDLE.
- Reset mid-instruction aborts the instruction with no write. A reset asserted during WRITE suppresses that edge's write.

Test Plan:
- Reset, then MOV R0,#0xFD (instr 0xD0FD) -> 1 cycle later rf_write=1, rf_writenum=0, rf_data_in=0xFFFD, done=1; instr_ready=1 the next cycle.
- Register file holds R1=5, R2=7; ADD R3,R1,R2 LSL1 (0xA16A) -> rf_anum=1 in cycle1, rf_bnum=2 in cycle2, cycle4 rf_write=1, writenum=3, data=0x0013; z/n/v unchanged.
- R1=0x7FFF, R2=0xFFFF; CMP R1,R2 (0xA902) -> done in cycle3; z=0, n=1, v=1, rf_write never asserted. Then CMP R1,R1 -> z=1, n=0, v=0.
- R4=0x8000; MVN R5,R4 LSR1 (0xB8B4) -> cycle3 rf_write=1, writenum=5, data=0xBFFF. Repeat with ASR1 (0xB8BC) -> data=0x3FFF.
- Opcode 111 (0xE000) -> next cycle done=1, illegal=1, rf_write=0, flags unchanged, IDLE after.
- ADD accepted, rst_n pulled low in cycle3 -> rf_write stays 0, instr_ready=0 while low; after release, state IDLE, z/n/v=0, the destination register holds its old value.
